cla_serial_nibble_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that processes one 4-bit carry-lookahead slice per clock,

---
 rtl/cla_serial_nibble_adder.sv | 88 ++++++++
 tb/tb_cla_serial_nibble_adder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cla_serial_nibble_adder.sv
// cla_serial_nibble_adder: multi-cycle adder, one 4-bit lookahead slice per clock, LSB nibble first
module cla_serial_nibble_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q, cout_q, ovf_q, in_ready_q, out_valid_q;
  logic [3:0]       na, nb, g, p, s;
  logic [4:0]       c;
  always_comb begin
    na   = a_q[4*idx_q +: 4];
    nb   = b_q[4*idx_q +: 4];
    g    = na & nb;
    p    = na ^ nb;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & carry_q);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry_q);
    s    = p ^ c[3:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= a;
          b_q        <= b;
          carry_q    <= cin;
          idx_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= s;
          carry_q             <= c[4];
          idx_q               <= idx_q + 1'b1;
          if (idx_q == IW'(N - 1)) begin
            cout_q      <= c[4];
            ovf_q       <= c[3] ^ c[4];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // ready is masked combinationally so it reads low throughout the reset cycle itself
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_serial_nibble_adder.sv
// tb_cla_serial_nibble_adder: directed and random vectors, scoreboard queue checked by a monitor
module tb_cla_serial_nibble_adder;
  localparam int W = 16;
  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
  typedef struct packed {logic [W-1:0] s; logic c; logic v;} exp_t;
  exp_t sb[$];
  int   checks = 0, errors = 0;
  bit   rand_or = 1'b0;

  cla_serial_nibble_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      input logic [W-1:0] es, input logic ec, input logic ev);
    int  n = 0;
    bit  ok = 1'b1;
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 200) begin
        chk("accept_timeout", 32'(in_ready), 32'(1));
        ok = 1'b0;
        break;
      end
      tick();
    end
    if (ok) sb.push_back('{es, ec, ev});
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (++lat > 50) begin
        chk("valid_timeout", 32'(out_valid), 32'(1));
        break;
      end
      tick();
    end
  endtask

  initial begin
    int   lat, seen;
    exp_t e;
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_output", 32'({sum, cout, ovf}), 32'(0));
          else chk("result", 32'({sum, cout, ovf}), 32'(sb.pop_front()));
        end
      end
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_outputs", 32'({sum, cout, ovf}), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'(1));
    tick();
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(4));
    tick();
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_valid(lat); tick();
    send(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    wait_valid(lat); tick();
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    wait_valid(lat); tick();
    send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_valid(lat); tick();
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    wait_valid(lat); tick();
    out_ready = 1'b0;
    send(16'h0F0F, 16'h1111, 1'b0, 16'h2020, 1'b0, 1'b0);
    wait_valid(lat);
    e = (sb.size() != 0) ? sb[0] : '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_stable", 32'({sum, cout, ovf}), 32'(e));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      @(posedge clk); #1;
      in_valid = (i == 0);
      a = 16'h0101; b = 16'h0202;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'(1));
    chk("release_out_valid", 32'(out_valid), 32'(0));
    seen = 0;
    repeat (8) begin @(negedge clk); seen += int'(out_valid); end
    chk("no_ghost_op", 32'(seen), 32'(0));
    tick();
    send(16'hAAAA, 16'h1111, 1'b0, 16'hBBBB, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'(0));
    chk("midrun_rst_idle", 32'(in_ready), 32'(1));
    chk("midrun_rst_sum", 32'(sum), 32'(0));
    sb.delete();
    tick();
    send(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
    wait_valid(lat); tick();
    rand_or = 1'b1;
    repeat (1000) begin
      logic [W-1:0] ta, tb_;
      logic         tc;
      logic [W:0]   r;
      ta  = W'($urandom); tb_ = W'($urandom); tc = 1'($urandom_range(0, 1));
      r   = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
      send(ta, tb_, tc, r[W-1:0], r[W], (ta[W-1] == tb_[W-1]) && (r[W-1] != ta[W-1]));
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    repeat (2) tick();
    chk("drain_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
